// File: rtl/xc_sha2_seq.sv
// SHA-256/SHA-512 sigma/Sigma unit with a valid/ready request and beat response.
// With XLEN=32 a SHA-512 result is returned as two beats, low word first.
module xc_sha2_seq #(
    parameter int XLEN = 32
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_last
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

    state_t          state_reg;
    logic            ready_en_reg;
    logic            rsp_valid_reg;
    logic            rsp_last_reg;
    logic [XLEN-1:0] rsp_result_reg;
    logic [XLEN-1:0] hi_reg;

    logic [31:0]     x32;
    logic [63:0]     x64;
    logic [31:0]     r256;
    logic [63:0]     r512;
    logic [XLEN-1:0] lo_next;
    logic [XLEN-1:0] hi_next;
    logic            two_beat;
    logic            accept;

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [31:0] f256(input logic [31:0] x, input logic [1:0] sel);
        logic [31:0] r;
        case (sel)
            2'b00:   r = ror32(x, 7)  ^ ror32(x, 18) ^ (x >> 3);
            2'b01:   r = ror32(x, 17) ^ ror32(x, 19) ^ (x >> 10);
            2'b10:   r = ror32(x, 2)  ^ ror32(x, 13) ^ ror32(x, 22);
            default: r = ror32(x, 6)  ^ ror32(x, 11) ^ ror32(x, 25);
        endcase
        return r;
    endfunction

    function automatic logic [63:0] f512(input logic [63:0] x, input logic [1:0] sel);
        logic [63:0] r;
        case (sel)
            2'b00:   r = ror64(x, 1)  ^ ror64(x, 8)  ^ (x >> 7);
            2'b01:   r = ror64(x, 19) ^ ror64(x, 61) ^ (x >> 6);
            2'b10:   r = ror64(x, 28) ^ ror64(x, 34) ^ ror64(x, 39);
            default: r = ror64(x, 14) ^ ror64(x, 18) ^ ror64(x, 41);
        endcase
        return r;
    endfunction

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("xc_sha2_seq: XLEN must be 32 or 64");
        end

        if (XLEN == 64) begin : g_x64
            logic unused_rs2;
            assign unused_rs2 = ^req_rs2;
            assign x64      = req_rs1;
            assign lo_next  = req_op[2] ? r512 : {32'b0, r256};
            assign hi_next  = '0;
            assign two_beat = 1'b0;
        end else begin : g_x32
            assign x64      = {req_rs2, req_rs1};
            assign lo_next  = req_op[2] ? r512[31:0] : r256;
            assign hi_next  = r512[63:32];
            assign two_beat = req_op[2];
        end
    endgenerate

    assign x32  = req_rs1[31:0];
    assign r256 = f256(x32, req_op[1:0]);
    assign r512 = f512(x64, req_op[1:0]);

    // A new request may overlap the handshake of the final beat of the previous one.
    assign req_ready = ready_en_reg & ~flush &
                       ((state_reg == IDLE) | (rsp_last_reg & rsp_ready));
    assign accept    = req_valid & req_ready;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_reg      <= IDLE;
            ready_en_reg   <= 1'b0;
            rsp_valid_reg  <= 1'b0;
            rsp_last_reg   <= 1'b0;
            rsp_result_reg <= '0;
            hi_reg         <= '0;
        end else begin
            ready_en_reg <= 1'b1;
            if (flush) begin
                state_reg     <= IDLE;
                rsp_valid_reg <= 1'b0;
                rsp_last_reg  <= 1'b0;
            end else if (accept) begin
                state_reg      <= BEAT0;
                rsp_valid_reg  <= 1'b1;
                rsp_last_reg   <= ~two_beat;
                rsp_result_reg <= lo_next;
                hi_reg         <= hi_next;
            end else if (state_reg != IDLE && rsp_ready) begin
                if (rsp_last_reg) begin
                    state_reg     <= IDLE;
                    rsp_valid_reg <= 1'b0;
                    rsp_last_reg  <= 1'b0;
                end else begin
                    state_reg      <= BEAT1;
                    rsp_last_reg   <= 1'b1;
                    rsp_result_reg <= hi_reg;
                end
            end
        end
    end

    assign rsp_valid  = rsp_valid_reg;
    assign rsp_last   = rsp_last_reg;
    assign rsp_result = rsp_result_reg;

endmodule

// File: tb/tb_xc_sha2_seq.sv
// Directed bench for xc_sha2_seq: one XLEN=32 and one XLEN=64 instance side by side.
// Expected values are hand-derived from the rotate/shift definitions.
module tb_xc_sha2_seq;

    logic        g_clk;
    logic        g_resetn;
    logic        flush;
    logic        rsp_ready;
    logic [2:0]  req_op;

    logic        valid32;
    logic [31:0] rs1_32;
    logic [31:0] rs2_32;
    logic        ready32;
    logic        rvalid32;
    logic [31:0] result32;
    logic        last32;

    logic        valid64;
    logic [63:0] rs1_64;
    logic [63:0] rs2_64;
    logic        ready64;
    logic        rvalid64;
    logic [63:0] result64;
    logic        last64;

    int checks = 0;
    int errors = 0;

    xc_sha2_seq #(.XLEN(32)) dut32 (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .flush      (flush),
        .req_valid  (valid32),
        .req_ready  (ready32),
        .req_op     (req_op),
        .req_rs1    (rs1_32),
        .req_rs2    (rs2_32),
        .rsp_valid  (rvalid32),
        .rsp_ready  (rsp_ready),
        .rsp_result (result32),
        .rsp_last   (last32)
    );

    xc_sha2_seq #(.XLEN(64)) dut64 (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .flush      (flush),
        .req_valid  (valid64),
        .req_ready  (ready64),
        .req_op     (req_op),
        .req_rs1    (rs1_64),
        .req_rs2    (rs2_64),
        .rsp_valid  (rvalid64),
        .rsp_ready  (rsp_ready),
        .rsp_result (result64),
        .rsp_last   (last64)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns one time unit after the next rising edge.
    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic single32(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] exp);
        req_op = op; rs1_32 = a; rs2_32 = 32'h0; valid32 = 1'b1; rsp_ready = 1'b1;
        #1 chk({tag, ".ready"}, 64'(ready32), 64'd1);
        tick();
        valid32 = 1'b0;
        #1;
        chk({tag, ".valid"}, 64'(rvalid32), 64'd1);
        chk({tag, ".result"}, 64'(result32), 64'(exp));
        chk({tag, ".last"}, 64'(last32), 64'd1);
        $display("txn %s op=%b rs1=%h result=%h last=%b", tag, op, a, result32, last32);
        tick();
        #1 chk({tag, ".idle"}, 64'(rvalid32), 64'd0);
    endtask

    task automatic single64(input string tag, input logic [2:0] op, input logic [63:0] a,
                            input logic [63:0] exp);
        req_op = op; rs1_64 = a; rs2_64 = 64'hFFFF_FFFF_FFFF_FFFF; valid64 = 1'b1; rsp_ready = 1'b1;
        #1 chk({tag, ".ready"}, 64'(ready64), 64'd1);
        tick();
        valid64 = 1'b0;
        #1;
        chk({tag, ".valid"}, 64'(rvalid64), 64'd1);
        chk({tag, ".result"}, result64, exp);
        chk({tag, ".last"}, 64'(last64), 64'd1);
        $display("txn %s op=%b rs1=%h result=%h last=%b", tag, op, a, result64, last64);
        tick();
        #1 chk({tag, ".idle"}, 64'(rvalid64), 64'd0);
    endtask

    initial begin
        g_resetn = 1'b0; flush = 1'b0; rsp_ready = 1'b0; req_op = 3'b000;
        valid32 = 1'b0; rs1_32 = '0; rs2_32 = '0;
        valid64 = 1'b0; rs1_64 = '0; rs2_64 = '0;

        // Reset values, then ready from the first edge after release.
        #3;
        chk("rst.valid", 64'(rvalid32), 64'd0);
        chk("rst.ready", 64'(ready32), 64'd0);
        chk("rst.result", 64'(result32), 64'd0);
        chk("rst.last", 64'(last32), 64'd0);
        #5 g_resetn = 1'b1;
        tick();
        #1;
        chk("rel.ready32", 64'(ready32), 64'd1);
        chk("rel.ready64", 64'(ready64), 64'd1);
        $display("txn reset released ready32=%b ready64=%b", ready32, ready64);

        // SHA-256 single-beat vectors on the 32-bit instance.
        single32("s256_sig0_1", 3'b000, 32'h0000_0001, 32'h0200_4000);
        single32("s256_sig0_msb", 3'b000, 32'h8000_0000, 32'h1100_2000);
        single32("s256_sig1_1", 3'b001, 32'h0000_0001, 32'h0000_A000);
        single32("s256_Sig1_1", 3'b011, 32'h0000_0001, 32'h0420_0080);

        // Three back-to-back Sigma0 requests: one beat per cycle, no bubbles.
        req_op = 3'b010; rs1_32 = 32'h1; rs2_32 = 32'h0; valid32 = 1'b1; rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) valid32 = 1'b0;
            #1;
            chk("b2b.valid", 64'(rvalid32), 64'd1);
            chk("b2b.result", 64'(result32), 64'h4008_0400);
            chk("b2b.last", 64'(last32), 64'd1);
            if (i < 2) chk("b2b.ready", 64'(ready32), 64'd1);
            $display("txn b2b beat %0d result=%h last=%b", i, result32, last32);
        end
        tick();
        #1 chk("b2b.idle", 64'(rvalid32), 64'd0);

        // SHA-512 sigma0 on XLEN=32: two beats, low word first.
        req_op = 3'b100; rs1_32 = 32'h1; rs2_32 = 32'h0; valid32 = 1'b1;
        tick();
        valid32 = 1'b0;
        #1;
        chk("s512.b0.valid", 64'(rvalid32), 64'd1);
        chk("s512.b0.result", 64'(result32), 64'h0);
        chk("s512.b0.last", 64'(last32), 64'd0);
        chk("s512.b0.ready", 64'(ready32), 64'd0);
        $display("txn s512 beat0 result=%h last=%b", result32, last32);
        tick();
        #1;
        chk("s512.b1.result", 64'(result32), 64'h8100_0000);
        chk("s512.b1.last", 64'(last32), 64'd1);
        chk("s512.b1.ready", 64'(ready32), 64'd1);
        $display("txn s512 beat1 result=%h last=%b", result32, last32);
        tick();
        #1 chk("s512.idle", 64'(rvalid32), 64'd0);

        // High-word input, then a new request accepted on the last-beat handshake.
        req_op = 3'b100; rs1_32 = 32'h0; rs2_32 = 32'h8000_0000; valid32 = 1'b1;
        tick();
        valid32 = 1'b0;
        #1 chk("ovl.b0.result", 64'(result32), 64'h0);
        tick();
        req_op = 3'b110; rs1_32 = 32'h1; rs2_32 = 32'h0; valid32 = 1'b1;
        #1;
        chk("ovl.b1.result", 64'(result32), 64'h4180_0000);
        chk("ovl.b1.ready", 64'(ready32), 64'd1);
        $display("txn ovl beat1 result=%h last=%b", result32, last32);
        tick();
        valid32 = 1'b0;
        #1;
        chk("ovl.n0.valid", 64'(rvalid32), 64'd1);
        chk("ovl.n0.result", 64'(result32), 64'h4200_0000);
        chk("ovl.n0.last", 64'(last32), 64'd0);
        tick();
        #1;
        chk("ovl.n1.result", 64'(result32), 64'h0000_0010);
        chk("ovl.n1.last", 64'(last32), 64'd1);
        $display("txn ovl new beat1 result=%h last=%b", result32, last32);
        tick();
        #1 chk("ovl.idle", 64'(rvalid32), 64'd0);

        // Stall beat0 for 5 cycles, then flush (which also blocks acceptance).
        req_op = 3'b101; rs1_32 = 32'h1; rs2_32 = 32'h0; valid32 = 1'b1; rsp_ready = 1'b0;
        tick();
        valid32 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall.valid", 64'(rvalid32), 64'd1);
            chk("stall.result", 64'(result32), 64'h0000_0008);
            chk("stall.last", 64'(last32), 64'd0);
            tick();
        end
        flush = 1'b1; valid32 = 1'b1;
        #1 chk("flush.ready", 64'(ready32), 64'd0);
        tick();
        flush = 1'b0; valid32 = 1'b0;
        #1;
        chk("flush.valid", 64'(rvalid32), 64'd0);
        chk("flush.idle_ready", 64'(ready32), 64'd1);
        $display("txn flush valid=%b ready=%b", rvalid32, ready32);
        tick();
        #1 chk("flush.noaccept", 64'(rvalid32), 64'd0);

        // XLEN=64 instance.
        single64("x64_Sig1_512", 3'b111, 64'h1, 64'h0004_4000_0080_0000);
        single64("x64_sig0_256", 3'b000, 64'hFFFF_FFFF_0000_0001, 64'h0000_0000_0200_4000);
        single64("x64_sig0_512", 3'b100, 64'h1, 64'h8100_0000_0000_0000);

        // Reset asserted during BEAT1 drops the response without a clock edge.
        req_op = 3'b111; rs1_32 = 32'h1; rs2_32 = 32'h0; valid32 = 1'b1; rsp_ready = 1'b0;
        tick();
        valid32 = 1'b0;
        #1 chk("rb.b0.result", 64'(result32), 64'h0080_0000);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        chk("rb.b1.result", 64'(result32), 64'h0004_4000);
        chk("rb.b1.last", 64'(last32), 64'd1);
        g_resetn = 1'b0;
        #1;
        chk("rb.valid", 64'(rvalid32), 64'd0);
        chk("rb.last", 64'(last32), 64'd0);
        chk("rb.result", 64'(result32), 64'd0);
        chk("rb.ready", 64'(ready32), 64'd0);
        $display("txn reset in beat1 valid=%b result=%h", rvalid32, result32);
        #1 g_resetn = 1'b1;
        tick();
        #1;
        chk("rb.rel.ready", 64'(ready32), 64'd1);
        chk("rb.rel.valid", 64'(rvalid32), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
